therm: RTL and testbench

//   Thermometer-code checker and decoder. Combinationally flags whether codeIn is a

---
 rtl/therm.sv | 87 ++++++++
 tb/tb_therm.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/therm.sv
// Thermometer-code checker/decoder with a registered sample stage and a
// sticky illegal-code flag for downstream status logic.
module therm #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LVL_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] codeIn,
  input  logic                  in_valid,
  input  logic                  err_clr,
  output logic                  isThermometer,
  output logic [LVL_W-1:0]      level,
  output logic                  therm_q,
  output logic [LVL_W-1:0]      level_q,
  output logic                  sample_vld_q,
  output logic                  err_sticky
);

  logic [DATA_WIDTH-1:0] code_inc;
  logic                  legal;
  logic [LVL_W-1:0]      ones_cnt;

  logic                  therm_d;
  logic [LVL_W-1:0]      level_d;
  logic                  sample_vld_d;
  logic                  err_sticky_d;
  logic                  err_sticky_q;

  // Legality check: adding 1 to a legal code carries through every one,
  // so the AND is zero only when no 0 sits below a 1.
  always_comb begin
    code_inc = codeIn + DATA_WIDTH'(1);
    legal    = ((codeIn & code_inc) == '0);
  end

  // Population count of the code under test.
  always_comb begin
    ones_cnt = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      ones_cnt = ones_cnt + LVL_W'(codeIn[i]);
    end
  end

  // Combinational outputs; level is forced to 0 for illegal codes.
  always_comb begin
    isThermometer = legal;
    level         = legal ? ones_cnt : '0;
  end

  // Next-state for the sample stage; hold path ignores codeIn entirely.
  always_comb begin
    therm_d      = therm_q;
    level_d      = level_q;
    sample_vld_d = 1'b0;
    err_sticky_d = err_sticky_q;
    if (err_clr) begin
      err_sticky_d = 1'b0;
    end
    if (in_valid) begin
      therm_d      = legal;
      level_d      = legal ? ones_cnt : '0;
      sample_vld_d = 1'b1;
      if (!legal) begin
        err_sticky_d = 1'b1;
      end
    end
  end

  // Sample registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      therm_q      <= 1'b1;
      level_q      <= '0;
      sample_vld_q <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      therm_q      <= therm_d;
      level_q      <= level_d;
      sample_vld_q <= sample_vld_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_therm.sv
// Self-checking bench for therm: directed cases, full 8-bit sweep and
// randomized traffic compared against a behavioural reference model.
module tb_therm;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] codeIn;
  logic          in_valid;
  logic          err_clr;
  logic          isThermometer;
  logic [LW-1:0] level;
  logic          therm_q;
  logic [LW-1:0] level_q;
  logic          sample_vld_q;
  logic          err_sticky;

  int n_checks;
  int n_errors;

  // Reference state of the registered stage
  logic          m_therm;
  int            m_level;
  logic          m_vld;
  logic          m_err;

  therm #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .codeIn        (codeIn),
    .in_valid      (in_valid),
    .err_clr       (err_clr),
    .isThermometer (isThermometer),
    .level         (level),
    .therm_q       (therm_q),
    .level_q       (level_q),
    .sample_vld_q  (sample_vld_q),
    .err_sticky    (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A legal code is exactly 2^k - 1 for some k in 0..DW; its level is k.
  task automatic ref_decode(input logic [DW-1:0] code, output logic legal, output int lvl);
    logic [DW:0] pat;
    legal = 1'b0;
    lvl   = 0;
    for (int k = 0; k <= int'(DW); k++) begin
      pat = ((DW+1)'(1) << k) - (DW+1)'(1);
      if (code == pat[DW-1:0]) begin
        legal = 1'b1;
        lvl   = k;
      end
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".therm_q"},      32'(therm_q),      32'(m_therm));
    check({tag, ".level_q"},      32'(level_q),      32'(m_level));
    check({tag, ".sample_vld_q"}, 32'(sample_vld_q), 32'(m_vld));
    check({tag, ".err_sticky"},   32'(err_sticky),   32'(m_err));
  endtask

  // Drive one cycle of stimulus, check combinational and registered outputs.
  task automatic step(input logic [DW-1:0] code, input logic vld, input logic clr, input string tag);
    logic legal;
    int   lvl;
    @(negedge clk);
    codeIn   = code;
    in_valid = vld;
    err_clr  = clr;
    #1;
    if (!$isunknown(code)) begin
      ref_decode(code, legal, lvl);
      check({tag, ".isThermometer"}, 32'(isThermometer), 32'(legal));
      check({tag, ".level"},         32'(level),         32'(legal ? lvl : 0));
    end else begin
      legal = 1'b1;
      lvl   = 0;
    end
    @(posedge clk);
    if (vld) begin
      m_therm = legal;
      m_level = legal ? lvl : 0;
      m_vld   = 1'b1;
      m_err   = legal ? (clr ? 1'b0 : m_err) : 1'b1;
    end else begin
      m_vld   = 1'b0;
      m_err   = clr ? 1'b0 : m_err;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic model_reset();
    m_therm = 1'b1;
    m_level = 0;
    m_vld   = 1'b0;
    m_err   = 1'b0;
  endtask

  initial begin
    logic [DW:0]   pat;
    logic [DW-1:0] code;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    codeIn   = '0;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    model_reset();

    // Reset state
    #12;
    check_regs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed decode cases
    step(8'b0000_1111, 1'b1, 1'b0, "d_0f");
    step(8'b1111_1111, 1'b1, 1'b0, "d_ff");
    step(8'b0000_0000, 1'b1, 1'b0, "d_00");
    step(8'b0111_1111, 1'b1, 1'b0, "d_7f");
    step(8'b1010_1010, 1'b0, 1'b0, "d_aa_hold");
    step(8'b1111_1110, 1'b0, 1'b0, "d_fe_hold");

    // Sticky error: set, clear with legal sample, set+clear coincide
    step(8'b1010_1010, 1'b1, 1'b0, "err_set");
    step(8'b0000_0011, 1'b1, 1'b1, "err_clr_legal");
    step(8'b1111_1110, 1'b1, 1'b1, "err_set_wins");
    step(8'b0000_0001, 1'b0, 1'b0, "err_hold");
    step(8'b0000_0001, 1'b0, 1'b1, "err_clr_idle");

    // X on codeIn with in_valid low must leave registers alone
    step(8'b0011_1111, 1'b1, 1'b0, "pre_x");
    step('x,           1'b0, 1'b0, "x_hold");
    step('x,           1'b0, 1'b0, "x_hold2");

    // Exhaustive sweep of all codes
    for (int c = 0; c < 256; c++) begin
      step(8'(c), 1'b1, ($urandom_range(0, 7) == 0), "sweep");
    end

    // Randomized traffic, biased toward legal codes
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        pat  = ((DW+1)'(1) << $urandom_range(0, DW)) - (DW+1)'(1);
        code = pat[DW-1:0];
      end else begin
        code = 8'($urandom);
      end
      step(code, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), "rand");
    end

    // Asynchronous reset between clock edges, with non-reset state present
    step(8'b1100_1100, 1'b1, 1'b0, "pre_arst");
    step(8'b0000_0111, 1'b1, 1'b0, "pre_arst2");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_regs("arst");
    @(negedge clk);
    rst = 1'b0;
    step(8'b0001_1111, 1'b1, 1'b0, "post_arst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
